// File: rtl/assoc_memory_search.sv
// Nearest-prototype search over stored language hypervectors, CHUNK bits of Hamming distance per cycle.
// Optional runner-up distance output enabled by defining AM_SECOND_BEST_EN.

module assoc_proto_regfile #(
    parameter int N           = 10000,
    parameter int NUM_CLASSES = 21,
    parameter int IDX_W       = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [N-1:0]     wr_data,
    input  logic [IDX_W-1:0] rd_class,
    output logic [N-1:0]     rd_row
);
    logic [N-1:0]           mem [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] wr_sel;

    // Slots beyond NUM_CLASSES never decode, so out-of-range writes are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            wr_sel[i] = wr_en && (wr_addr == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (wr_sel[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_row = '0;
        if (int'(rd_class) < NUM_CLASSES) begin
            rd_row = mem[rd_class];
        end
    end
endmodule

// state  | meaning
// IDLE   | ready for a query; prototype loads accepted
// SEARCH | one chunk of one class compared per cycle
// DONE   | result presented, held until resultReady
module assoc_memory_search #(
    parameter int N           = 10000,
    parameter int NUM_CLASSES = 21,
    parameter int CHUNK       = 500,
    parameter int IDX_W       = 5,
    parameter int DIST_W      = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loadEn,
    input  logic [IDX_W-1:0]  loadAddr,
    input  logic [N-1:0]      loadVector,
    input  logic              queryValid,
    output logic              queryReady,
    input  logic [N-1:0]      queryVector,
    output logic              resultValid,
    input  logic              resultReady,
    output logic [IDX_W-1:0]  resultClass,
    output logic [DIST_W-1:0] resultDistance,
`ifdef AM_SECOND_BEST_EN
    output logic [DIST_W-1:0] secondDistance,
`endif
    output logic              busy
);
    localparam int NCHUNK = N / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PW     = $clog2(CHUNK + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t             state, state_nxt;
    logic [N-1:0]       q_reg;
    logic [N-1:0]       proto_row;
    logic [N-1:0]       diff;
    logic [CHUNK-1:0]   diff_chunks [NCHUNK];
    logic [CHUNK-1:0]   diff_sel;
    logic [PW-1:0]      partial;
    logic [CW-1:0]      chunk_cnt;
    logic [IDX_W-1:0]   class_cnt;
    logic [IDX_W-1:0]   best_idx, best_idx_nxt;
    logic [DIST_W-1:0]  acc, total;
    logic [DIST_W-1:0]  best, best_nxt;
    logic               accept, load_we;
    logic               last_chunk, last_class, take_best;

    assoc_proto_regfile #(
        .N           (N),
        .NUM_CLASSES (NUM_CLASSES),
        .IDX_W       (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .wr_en    (load_we),
        .wr_addr  (loadAddr),
        .wr_data  (loadVector),
        .rd_class (class_cnt),
        .rd_row   (proto_row)
    );

    assign diff = q_reg ^ proto_row;

    for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
        assign diff_chunks[c] = diff[c*CHUNK +: CHUNK];
    end

    assign diff_sel = diff_chunks[chunk_cnt];

    always_comb begin
        partial = '0;
        for (int i = 0; i < CHUNK; i++) begin
            partial = partial + PW'(diff_sel[i]);
        end
    end

    // Accumulator never exceeds N, which fits DIST_W by construction.
    assign total      = acc + DIST_W'(partial);
    assign last_chunk = (chunk_cnt == CW'(NCHUNK - 1));
    assign last_class = (class_cnt == IDX_W'(NUM_CLASSES - 1));
    // Strict less-than keeps the lower index on ties.
    assign take_best  = (class_cnt == '0) || (total < best);

    always_comb begin
        best_nxt     = best;
        best_idx_nxt = best_idx;
        if (take_best) begin
            best_nxt     = total;
            best_idx_nxt = class_cnt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_we   = 1'b0;
        case (state)
            IDLE: begin
                load_we = loadEn && rst;
                if (queryValid) begin
                    accept    = 1'b1;
                    state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (last_chunk && last_class) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (resultReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign queryReady = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (accept) begin
            q_reg <= queryVector;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            chunk_cnt      <= '0;
            class_cnt      <= '0;
            acc            <= '0;
            best           <= '0;
            best_idx       <= '0;
            resultValid    <= 1'b0;
            resultClass    <= '0;
            resultDistance <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        chunk_cnt <= '0;
                        class_cnt <= '0;
                        acc       <= '0;
                    end
                end
                SEARCH: begin
                    if (last_chunk) begin
                        chunk_cnt <= '0;
                        acc       <= '0;
                        best      <= best_nxt;
                        best_idx  <= best_idx_nxt;
                        if (last_class) begin
                            class_cnt      <= '0;
                            resultValid    <= 1'b1;
                            resultClass    <= best_idx_nxt;
                            resultDistance <= best_nxt;
                        end else begin
                            class_cnt <= class_cnt + 1'b1;
                        end
                    end else begin
                        chunk_cnt <= chunk_cnt + 1'b1;
                        acc       <= total;
                    end
                end
                DONE: begin
                    if (resultReady) begin
                        resultValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AM_SECOND_BEST_EN
    logic [DIST_W-1:0] second, second_nxt;

    // A displaced best becomes the runner-up; a tie with best lands here too.
    always_comb begin
        second_nxt = second;
        if (class_cnt == '0) begin
            second_nxt = DIST_W'(N);
        end else if (total < best) begin
            second_nxt = best;
        end else if (total < second) begin
            second_nxt = total;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            second         <= '0;
            secondDistance <= '0;
        end else if (state == SEARCH && last_chunk) begin
            second <= second_nxt;
            if (last_class) begin
                secondDistance <= second_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_assoc_memory_search.sv
// Directed bench for assoc_memory_search at N=64, CHUNK=16, NUM_CLASSES=4 plus a 3-class instance.
// Runner-up distance checks are compiled in when AM_SECOND_BEST_EN is defined.

module tb_assoc_memory_search;
    localparam int N      = 64;
    localparam int CHUNK  = 16;
    localparam int NC     = 4;
    localparam int IDX_W  = 2;
    localparam int DIST_W = 7;

    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] LOW32 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] ALT   = 64'h5555_5555_5555_5555;
    localparam logic [63:0] NIB   = 64'h0000_0000_0000_000F;
    localparam logic [63:0] MIX   = 64'h0123_4567_89AB_CDEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              loadEn;
    logic [IDX_W-1:0]  loadAddr;
    logic [N-1:0]      loadVector;
    logic              queryValid;
    logic              queryReady;
    logic [N-1:0]      queryVector;
    logic              resultValid;
    logic              resultReady;
    logic [IDX_W-1:0]  resultClass;
    logic [DIST_W-1:0] resultDistance;
    logic              busy;
`ifdef AM_SECOND_BEST_EN
    logic [DIST_W-1:0] secondDistance;
    logic [DIST_W-1:0] second_3;
`endif

    logic              l3_en;
    logic [IDX_W-1:0]  l3_addr;
    logic [N-1:0]      l3_vec;
    logic              q3_valid;
    logic              q3_ready;
    logic [N-1:0]      q3_vec;
    logic              r3_valid;
    logic              r3_ready;
    logic [IDX_W-1:0]  r3_class;
    logic [DIST_W-1:0] r3_dist;
    logic              busy_3;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assoc_memory_search #(
        .N(N), .NUM_CLASSES(NC), .CHUNK(CHUNK), .IDX_W(IDX_W), .DIST_W(DIST_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .loadEn         (loadEn),
        .loadAddr       (loadAddr),
        .loadVector     (loadVector),
        .queryValid     (queryValid),
        .queryReady     (queryReady),
        .queryVector    (queryVector),
        .resultValid    (resultValid),
        .resultReady    (resultReady),
        .resultClass    (resultClass),
        .resultDistance (resultDistance),
`ifdef AM_SECOND_BEST_EN
        .secondDistance (secondDistance),
`endif
        .busy           (busy)
    );

    assoc_memory_search #(
        .N(N), .NUM_CLASSES(3), .CHUNK(CHUNK), .IDX_W(IDX_W), .DIST_W(DIST_W)
    ) dut3 (
        .clk            (clk),
        .rst            (rst),
        .loadEn         (l3_en),
        .loadAddr       (l3_addr),
        .loadVector     (l3_vec),
        .queryValid     (q3_valid),
        .queryReady     (q3_ready),
        .queryVector    (q3_vec),
        .resultValid    (r3_valid),
        .resultReady    (r3_ready),
        .resultClass    (r3_class),
        .resultDistance (r3_dist),
`ifdef AM_SECOND_BEST_EN
        .secondDistance (second_3),
`endif
        .busy           (busy_3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [IDX_W-1:0] addr, input logic [63:0] vec);
        loadEn     = 1'b1;
        loadAddr   = addr;
        loadVector = vec;
        step();
        loadEn     = 1'b0;
    endtask

    task automatic run_query(input logic [63:0] qv, input bit ld, input logic [IDX_W-1:0] la,
                             input logic [63:0] lv, input int exp_cls, input int exp_dist,
                             input int exp_sec);
        int cyc;
        chk("ready_before_query", queryReady, 1'b1);
        queryVector = qv;
        queryValid  = 1'b1;
        loadEn      = ld;
        loadAddr    = la;
        loadVector  = lv;
        step();
        queryValid  = 1'b0;
        loadEn      = 1'b0;
        chk("busy_in_search", busy, 1'b1);
        chk("ready_low_in_search", queryReady, 1'b0);
        cyc = 0;
        while (resultValid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("latency", cyc, 16);
        chk("result_class", resultClass, exp_cls);
        chk("result_distance", resultDistance, exp_dist);
`ifdef AM_SECOND_BEST_EN
        chk("second_distance", secondDistance, exp_sec);
`endif
    endtask

    task automatic ack();
        resultReady = 1'b1;
        step();
        resultReady = 1'b0;
        chk("valid_drops_after_ack", resultValid, 1'b0);
        chk("ready_after_ack", queryReady, 1'b1);
    endtask

    initial begin
        int cyc;
        rst = 1'b0;
        loadEn = 1'b0; loadAddr = '0; loadVector = '0;
        queryValid = 1'b0; queryVector = '0; resultReady = 1'b0;
        l3_en = 1'b0; l3_addr = '0; l3_vec = '0;
        q3_valid = 1'b0; q3_vec = '0; r3_ready = 1'b0;
        step();
        step();
        rst = 1'b1;

        chk("reset_valid", resultValid, 1'b0);
        chk("reset_class", resultClass, 0);
        chk("reset_distance", resultDistance, 0);
        chk("reset_ready", queryReady, 1'b1);
        chk("reset_busy", busy, 1'b0);
`ifdef AM_SECOND_BEST_EN
        chk("reset_second", secondDistance, 0);
`endif

        // Distances to all-ones: 64, 0, 32, 32.
        load(0, 64'h0);
        load(1, ONES);
        load(2, LOW32);
        load(3, ALT);
        run_query(ONES, 0, 0, 0, 1, 0, 32);
        ack();

        // Distances to 0xF: 4, 60, 28, 32.
        run_query(NIB, 0, 0, 0, 0, 4, 28);
        ack();

        // Load during search is ignored, then reset aborts the search.
        queryVector = ONES;
        queryValid  = 1'b1;
        step();
        queryValid  = 1'b0;
        step(); step(); step();
        load(0, ONES);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_valid", resultValid, 1'b0);
        chk("abort_ready", queryReady, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_class", resultClass, 0);
        chk("abort_distance", resultDistance, 0);
        for (int i = 0; i < 20; i++) step();
        chk("abort_no_result", resultValid, 1'b0);
        run_query(NIB, 0, 0, 0, 0, 4, 28);
        ack();

        // Tie at distance 0 between slots 2 and 3; slots 0/1 sit at 32.
        load(2, MIX);
        load(3, MIX);
        run_query(MIX, 0, 0, 0, 2, 0, 0);
        for (int i = 0; i < 10; i++) begin
            queryValid  = 1'b1;
            queryVector = ONES;
            step();
            chk("hold_valid", resultValid, 1'b1);
            chk("hold_class", resultClass, 2);
            chk("hold_distance", resultDistance, 0);
            chk("hold_ready_low", queryReady, 1'b0);
        end
        queryValid = 1'b0;
        ack();
        chk("idle_keeps_class", resultClass, 2);
        step();
        chk("idle_no_accept", busy, 1'b0);

        // Slot 3 loaded with 0xF on the accepting edge: distances 4, 60, 28, 0.
        run_query(NIB, 1, 3, NIB, 3, 0, 4);
        ack();

        // Three-class build: address 3 is out of range; distances to 0 are 64, 32, 8.
        l3_en = 1'b1;
        l3_addr = 0; l3_vec = ONES;                   step();
        l3_addr = 1; l3_vec = 64'hFFFF_FFFF_0000_0000; step();
        l3_addr = 2; l3_vec = 64'h0000_0000_0000_00FF; step();
        l3_addr = 3; l3_vec = 64'h0;                  step();
        l3_en = 1'b0;
        q3_vec   = 64'h0;
        q3_valid = 1'b1;
        step();
        q3_valid = 1'b0;
        cyc = 0;
        while (r3_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("nc3_latency", cyc, 12);
        chk("nc3_class", r3_class, 2);
        chk("nc3_distance", r3_dist, 8);
`ifdef AM_SECOND_BEST_EN
        chk("nc3_second", second_3, 32);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/assoc_memory_search.md
Name: assoc_memory_search

Overview:
- Downstream of the n-gram encoder; consumes its thresholded N-bit text hypervector.
- Holds NUM_CLASSES trained language prototype hypervectors, loaded through a write port.
- On each query, computes the Hamming distance to every prototype, processing CHUNK bits per cycle.
- Returns the index and distance of the nearest prototype over a valid/ready handshake.

Parameters:
- N, 10000, hypervector width; must be a multiple of CHUNK.
- NUM_CLASSES, 21, number of stored language prototypes.
- CHUNK, 500, bits XOR-popcounted per cycle.
- IDX_W, 5, class index width; must satisfy 2^IDX_W >= NUM_CLASSES.
- DIST_W, 14, distance width; must satisfy 2^DIST_W > N.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- loadEn  input  1  write loadVector into prototype slot loadAddr.
- loadAddr  input  IDX_W  prototype slot index.
- loadVector  input  N  prototype hypervector.
- queryValid  input  1  queryVector valid.
- queryReady  output  1  block can accept a query.
- queryVector  input  N  text hypervector to classify.
- resultValid  output  1  result available.
- resultReady  input  1  consumer accepts the result.
- resultClass  output  IDX_W  index of the nearest prototype.
- resultDistance  output  DIST_W  Hamming distance to that prototype.
- busy  output  1  high in SEARCH or DONE.

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE; resultValid=0, resultClass=0, resultDistance=0.
  - Internal chunk counter, class counter and accumulator cleared.
  - Prototype storage is not cleared.
- Reset mid-search aborts the search; no result is produced.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - queryReady=1.
  - queryValid&&queryReady at an edge latches queryVector, sets class=0, chunk=0, acc=0, and moves to SEARCH.
- SEARCH:
  - queryReady=0.
  - Each cycle: acc += popcount(q[chunk] ^ proto[class][chunk]).
  - On the last chunk, total = acc + current partial.
  - If class==0 or total < best: best=total, bestIdx=class. A strict compare means ties keep the lower index.
  - Then chunk=0, acc=0, class++.
  - After the last chunk of class NUM_CLASSES-1, move to DONE with resultClass=bestIdx and resultDistance=best.
- Latency: a query accepted at edge T gives resultValid=1 after edge T+NUM_CLASSES*(N/CHUNK). With defaults that is 420 cycles.
- DONE:
  - resultValid=1; outputs held stable until resultValid&&resultReady at an edge.
  - On acceptance: resultValid=0, state=IDLE. queryReady first rises the cycle after acceptance, so no back-to-back accept in the same cycle.
- resultClass and resultDistance keep their last values in IDLE.
- Load rules:
  - loadEn is honoured only in IDLE.
  - loadEn in SEARCH or DONE is ignored.
  - loadAddr >= NUM_CLASSES is ignored.
  - If loadEn and a query accept occur in the same IDLE cycle, the load commits first. The search then uses the new prototype.
- Arithmetic: the accumulator is DIST_W bits wide and cannot overflow because the maximum is N.
- Distance 0 (exact match) and distance N are both legal.

Optional Feature:
- Macro AM_SECOND_BEST_EN.
- When defined:
  - Adds output secondDistance (DIST_W), holding the runner-up distance.
  - On each class total: if it replaces best, the previous best moves to second. Otherwise, if total < second, second takes total.
  - second is initialised to N when class 0 completes.
  - A tie with best sets second equal to best.
  - secondDistance is valid with resultValid and resets to 0.
- When undefined: no port and no logic; timing is otherwise identical.

Test Plan (N=64, CHUNK=16, NUM_CLASSES=4, IDX_W=2, DIST_W=7):
- Load protos 0..3 = 0, all-ones, 0x00000000FFFFFFFF, 0x5555...; query all-ones -> after 16 cycles resultClass=1, resultDistance=0. With the macro, secondDistance=32.
- Query 0x000000000000000F -> resultClass=0, resultDistance=4.
- Protos 2 and 3 identical, query = that value, other protos far -> resultClass=2 (lower index wins tie).
- Hold resultReady=0 for 10 cycles -> resultValid and outputs stable; queryValid ignored and queryReady=0. Assert resultReady -> next cycle resultValid=0, queryReady=1.
- loadEn to slot 0 during SEARCH, then assert rst mid-search -> load has no effect on this search; after reset resultValid=0 and state IDLE. A new query completes normally using the original proto 0.
- loadAddr=3 in the same cycle as a query accept -> the result reflects the new proto 3. loadAddr beyond NUM_CLASSES on a non-power-of-two build leaves all slots unchanged.
